// File: rtl/ball_frame_sequencer_if.sv
// Signal bundle between the raster timing source, the ball frame sequencer and the renderer.
// The slave modport is the sequencer's view; master is the driving/observing side.
interface ball_frame_sequencer_if;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [1:0] speed_sel;
    logic       pause;
    logic       step;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic       busy;
    logic       frame_done;
    logic       bounce_x;
    logic       bounce_y;
    logic [7:0] frame_cnt;
    logic [7:0] bounce_cnt;

    modport slave (
        input  hpos, vpos, speed_sel, pause, step,
        output ball_x, ball_y, dir_x, dir_y, busy, frame_done,
               bounce_x, bounce_y, frame_cnt, bounce_cnt
    );

    modport master (
        output hpos, vpos, speed_sel, pause, step,
        input  ball_x, ball_y, dir_x, dir_y, busy, frame_done,
               bounce_x, bounce_y, frame_cnt, bounce_cnt
    );
endinterface

// File: rtl/ball_frame_sequencer.sv
// Once-per-frame ball motion sequencer: IDLE -> CALC_X -> CALC_Y -> COMMIT, fired at the start of vblank.
// Optional macro BALL_SEQ_BOUNCE_CNT_EN builds the saturating bounce counter; otherwise bounce_cnt is 0.
module ball_frame_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BALL_R   = 20,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int V_TRIG   = 480
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ball_frame_sequencer_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC_X = 2'd1;
    localparam logic [1:0] ST_CALC_Y = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    localparam logic [10:0] POS_LO    = 11'(BALL_R);
    localparam logic [10:0] X_HI      = 11'(H_ACTIVE - BALL_R);
    localparam logic [10:0] Y_HI      = 11'(V_ACTIVE - BALL_R);
    localparam logic [9:0]  X_RST     = 10'(X_INIT);
    localparam logic [9:0]  Y_RST     = 10'(Y_INIT);
    localparam logic [9:0]  TRIG_LINE = 10'(V_TRIG);

    logic [1:0] state;
    logic       upd;
    logic       step_armed;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic       busy;
    logic       frame_done;
    logic       bounce_x;
    logic       bounce_y;
    logic [7:0] frame_cnt;

    logic [2:0] spd;
    logic [9:0] nx;
    logic [9:0] ny;
    logic       ndx;
    logic       ndy;
    logic       flip_x;
    logic       flip_y;

    logic trig;
    assign trig = (bus.hpos == 10'd0) && (bus.vpos == TRIG_LINE);

    // Result packs {flip, new_dir, new_pos}; the wall is reached when the step would touch or cross it.
    function automatic logic [11:0] step_axis(input logic [9:0]  pos,
                                              input logic        dir,
                                              input logic [2:0]  s,
                                              input logic [10:0] lo,
                                              input logic [10:0] hi);
        logic [10:0] sum;
        logic [10:0] lim;
        logic [10:0] diff;
        sum  = {1'b0, pos} + {8'd0, s};
        lim  = lo + {8'd0, s};
        diff = {1'b0, pos} - {8'd0, s};
        if (dir) begin
            if (sum >= hi) step_axis = {1'b1, 1'b0, hi[9:0]};
            else           step_axis = {1'b0, 1'b1, sum[9:0]};
        end else begin
            if ({1'b0, pos} <= lim) step_axis = {1'b1, 1'b1, lo[9:0]};
            else                    step_axis = {1'b0, 1'b0, diff[9:0]};
        end
    endfunction

    // Shadow datapath: speed latch and per-axis results, never observed directly.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && trig)
            spd <= {1'b0, bus.speed_sel} + 3'd1;
        if (state == ST_CALC_X)
            {flip_x, ndx, nx} <= step_axis(ball_x, dir_x, spd, POS_LO, X_HI);
        if (state == ST_CALC_Y)
            {flip_y, ndy, ny} <= step_axis(ball_y, dir_y, spd, POS_LO, Y_HI);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            upd        <= 1'b0;
            step_armed <= 1'b0;
            ball_x     <= X_RST;
            ball_y     <= Y_RST;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        upd       <= !bus.pause || step_armed;
                        frame_cnt <= frame_cnt + 8'd1;
                        busy      <= 1'b1;
                        state     <= ST_CALC_X;
                    end
                end
                ST_CALC_X: state <= ST_CALC_Y;
                ST_CALC_Y: state <= ST_COMMIT;
                default: begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= ST_IDLE;
                    if (upd) begin
                        ball_x     <= nx;
                        ball_y     <= ny;
                        dir_x      <= ndx;
                        dir_y      <= ndy;
                        bounce_x   <= flip_x;
                        bounce_y   <= flip_y;
                        step_armed <= 1'b0;
                    end
                end
            endcase
            // A step landing in the commit cycle re-arms: the set must override the clear above.
            if (bus.pause && bus.step)
                step_armed <= 1'b1;
        end
    end

`ifdef BALL_SEQ_BOUNCE_CNT_EN
    logic [7:0] bounce_cnt;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] t;
        t = {1'b0, a} + {7'd0, b};
        sat_add8 = t[8] ? 8'hFF : t[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n)
            bounce_cnt <= 8'd0;
        else if (state == ST_COMMIT && upd)
            bounce_cnt <= sat_add8(bounce_cnt, {1'b0, flip_x} + {1'b0, flip_y});
    end

    assign bus.bounce_cnt = bounce_cnt;
`else
    assign bus.bounce_cnt = 8'd0;
`endif

    assign bus.ball_x     = ball_x;
    assign bus.ball_y     = ball_y;
    assign bus.dir_x      = dir_x;
    assign bus.dir_y      = dir_y;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.bounce_x   = bounce_x;
    assign bus.bounce_y   = bounce_y;
    assign bus.frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_ball_frame_sequencer.sv
// Bench for ball_frame_sequencer: directed scenarios plus randomized traffic, checked every cycle
// against a frame-level behavioural model.
module tb_ball_frame_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ball_frame_sequencer_if bif();

    ball_frame_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec motion rule on one axis, in plain integers.
    function automatic void move(input int p, input bit d, input int s, input int lo, input int hi,
                                 output int np, output bit nd, output bit fl);
        if (d) begin
            if (p + s >= hi) begin np = hi; nd = 1'b0; fl = 1'b1; end
            else             begin np = p + s; nd = 1'b1; fl = 1'b0; end
        end else begin
            if (p <= lo + s) begin np = lo; nd = 1'b1; fl = 1'b1; end
            else             begin np = p - s; nd = 1'b0; fl = 1'b0; end
        end
    endfunction

    // Frame-level model: a trigger books a pending result that lands three edges later.
    bit m_valid = 1'b0;
    int m_x, m_y, m_fc, m_bc, cd;
    bit m_dx, m_dy, m_fd, m_bx, m_by, armed;
    int p_x, p_y;
    bit p_dx, p_dy, p_fx, p_fy, p_upd;

    always @(posedge clk) begin
        m_fd = 1'b0; m_bx = 1'b0; m_by = 1'b0;
        if (!rst_n) begin
            m_valid = 1'b1;
            m_x = 320; m_y = 240; m_dx = 1'b1; m_dy = 1'b1;
            m_fc = 0; m_bc = 0; cd = 0; armed = 1'b0;
        end else if (m_valid) begin
            if (cd == 1) begin
                cd = 0;
                m_fd = 1'b1;
                if (p_upd) begin
                    m_x = p_x; m_y = p_y; m_dx = p_dx; m_dy = p_dy;
                    m_bx = p_fx; m_by = p_fy;
                    armed = 1'b0;
`ifdef BALL_SEQ_BOUNCE_CNT_EN
                    m_bc = m_bc + int'(p_fx) + int'(p_fy);
                    if (m_bc > 255) m_bc = 255;
`endif
                end
            end else if (cd > 1) begin
                cd = cd - 1;
            end else if (bif.hpos == 0 && bif.vpos == 480) begin
                int s;
                s = int'(bif.speed_sel) + 1;
                move(m_x, m_dx, s, 20, 620, p_x, p_dx, p_fx);
                move(m_y, m_dy, s, 20, 460, p_y, p_dy, p_fy);
                p_upd = !bif.pause || armed;
                m_fc = (m_fc + 1) % 256;
                cd = 3;
            end
            if (bif.pause && bif.step) armed = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ball_x",     int'(bif.ball_x),     m_x);
            chk("ball_y",     int'(bif.ball_y),     m_y);
            chk("dir_x",      int'(bif.dir_x),      int'(m_dx));
            chk("dir_y",      int'(bif.dir_y),      int'(m_dy));
            chk("busy",       int'(bif.busy),       int'(cd != 0));
            chk("frame_done", int'(bif.frame_done), int'(m_fd));
            chk("bounce_x",   int'(bif.bounce_x),   int'(m_bx));
            chk("bounce_y",   int'(bif.bounce_y),   int'(m_by));
            chk("frame_cnt",  int'(bif.frame_cnt),  m_fc);
            chk("bounce_cnt", int'(bif.bounce_cnt), m_bc);
        end
    end

    int fd_seen;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_trig(input bit on);
        bif.hpos = on ? 10'd0 : 10'd5;
        bif.vpos = on ? 10'd480 : 10'd100;
    endtask

    task automatic frame();
        set_trig(1'b1);
        tick();
        set_trig(1'b0);
        repeat (4) begin
            tick();
            if (bif.frame_done) fd_seen++;
        end
    endtask

    task automatic pulse_step();
        bif.step = 1'b1;
        tick();
        bif.step = 1'b0;
        tick();
    endtask

    initial begin
        int np;
        bit nd, fl;
        int busy_cnt, fd_at;

        rst_n = 1'b0;
        bif.speed_sel = 2'd1;
        bif.pause = 1'b0;
        bif.step = 1'b0;
        set_trig(1'b0);

        // Pin the model's axis rule with hand-computed cases.
        move(618, 1'b1, 4, 20, 620, np, nd, fl);
        chk("model_right_wall_pos", np, 620); chk("model_right_wall_flip", int'(fl), 1);
        chk("model_right_wall_dir", int'(nd), 0);
        move(620, 1'b0, 4, 20, 620, np, nd, fl);
        chk("model_after_wall", np, 616); chk("model_after_wall_flip", int'(fl), 0);
        move(22, 1'b0, 2, 20, 460, np, nd, fl);
        chk("model_left_wall_pos", np, 20); chk("model_left_wall_dir", int'(nd), 1);

        tick(); tick();
        rst_n = 1'b1;
        chk("rst_ball_x", int'(bif.ball_x), 320);
        chk("rst_ball_y", int'(bif.ball_y), 240);
        chk("rst_frame_cnt", int'(bif.frame_cnt), 0);

        // First trigger: busy for three cycles, result on the third edge.
        bif.speed_sel = 2'd1;
        set_trig(1'b1);
        tick();
        set_trig(1'b0);
        busy_cnt = 0; fd_at = -1;
        for (int i = 0; i < 6; i++) begin
            if (bif.busy) busy_cnt++;
            if (bif.frame_done) fd_at = i;
            tick();
        end
        chk("first_busy_cycles", busy_cnt, 3);
        chk("first_frame_done_at", fd_at, 3);
        chk("first_ball_x", int'(bif.ball_x), 322);
        chk("first_ball_y", int'(bif.ball_y), 242);

        // Pause freezes position but frames still count and complete.
        bif.pause = 1'b1;
        fd_seen = 0;
        repeat (3) frame();
        chk("pause_ball_x", int'(bif.ball_x), 322);
        chk("pause_frame_cnt", int'(bif.frame_cnt), 4);
        chk("pause_frame_done", fd_seen, 3);
        pulse_step();
        pulse_step();
        frame();
        chk("step_ball_x", int'(bif.ball_x), 324);
        chk("step_ball_y", int'(bif.ball_y), 244);
        frame();
        chk("step_hold_x", int'(bif.ball_x), 324);
        bif.pause = 1'b0;
        pulse_step();
        bif.pause = 1'b1;
        frame();
        chk("unpaused_step_ignored", int'(bif.ball_x), 324);
        bif.pause = 1'b0;

        // Reset landing in CALC_Y.
        set_trig(1'b1);
        tick();
        set_trig(1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_ball_x", int'(bif.ball_x), 320);
        chk("midrst_busy", int'(bif.busy), 0);
        chk("midrst_frame_done", int'(bif.frame_done), 0);
        fd_seen = 0;
        repeat (4) begin
            tick();
            if (bif.frame_done) fd_seen++;
        end
        chk("midrst_no_pulse", fd_seen, 0);

        // frame_cnt wrap.
        repeat (255) frame();
        chk("wrap_255", int'(bif.frame_cnt), 255);
        frame();
        chk("wrap_0", int'(bif.frame_cnt), 0);

        // Randomized traffic, including held triggers, pause/step and occasional resets.
        for (int c = 0; c < 6000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 2) == 0) set_trig(1'b1);
            else if ($urandom_range(0, 1) == 0) begin
                bif.hpos = 10'($urandom_range(1, 799));
                bif.vpos = 10'd480;
            end else begin
                bif.hpos = 10'($urandom_range(0, 799));
                bif.vpos = 10'($urandom_range(0, 479));
            end
            bif.speed_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bif.pause = ~bif.pause;
            bif.step = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
